// File: rtl/vs_dma_pkg.sv
// Shared types and helpers for the video stream DMA multi-buffer controllers.
// Holds the controller state encoding, the buffer-index width and ring index arithmetic.
package vs_dma_pkg;

    localparam int BUFN_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        WRITING = 2'd2
    } vs_state_e;

    // Ring advance without a divider; values at or past the last slot wrap to 0.
    function automatic logic [BUFN_W-1:0] next_bufn(
        input logic [BUFN_W-1:0] cur,
        input logic [BUFN_W-1:0] last
    );
        return (cur >= last) ? '0 : cur + 1'b1;
    endfunction

endpackage

// File: rtl/vs_edge_det.sv
// Active-edge detector for a synchronous level; POL selects which level counts as active.
// The rise output is combinational against the one-cycle-delayed normalised level.
module vs_edge_det #(
    parameter logic POL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_i,
    output logic rise_o
);

    logic lvl;
    logic lvl_p0;

    assign lvl = sig_i ^ ~POL;

    // Stage p0: previous normalised level, cleared to inactive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_p0 <= 1'b0;
        end else begin
            lvl_p0 <= lvl;
        end
    end

    assign rise_o = lvl & ~lvl_p0;

endmodule

// File: rtl/vs_wbuf_ctrl.sv
// Write-side frame-buffer index controller: picks the buffer the write DMA fills and
// publishes the last completed buffer to the read side, flagging overrun frame starts.
module vs_wbuf_ctrl
    import vs_dma_pkg::*;
#(
    parameter int BUF_LENTH   = 3,
    parameter int VS_POL      = 1,
    parameter int FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   enable_i,
    input  logic                   vs_i,
    input  logic                   frame_done_i,
    output logic [BUFN_W-1:0]      wr_bufn_o,
    output logic [BUFN_W-1:0]      rd_bufn_o,
    output logic                   rd_valid_o,
    output logic                   frame_start_o,
    output logic                   drop_o,
    output logic                   busy_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

    localparam logic [1:0] ST_IDLE    = 2'(IDLE);
    localparam logic [1:0] ST_WAIT_VS = 2'(WAIT_VS);
    localparam logic [1:0] ST_WRITING = 2'(WRITING);

    localparam logic [BUFN_W-1:0] LAST_BUFN = BUFN_W'(BUF_LENTH - 1);

    logic [1:0] state_q;
    logic       vs_rise;

    vs_edge_det #(
        .POL (VS_POL != 0)
    ) u_vs_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .sig_i  (vs_i),
        .rise_o (vs_rise)
    );

    // Completion always lands before a coincident frame start, so the new frame
    // is accepted into the already advanced index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            wr_bufn_o     <= '0;
            rd_bufn_o     <= LAST_BUFN;
            rd_valid_o    <= 1'b0;
            frame_start_o <= 1'b0;
            drop_o        <= 1'b0;
            frame_cnt_o   <= '0;
        end else begin
            frame_start_o <= 1'b0;
            drop_o        <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (enable_i) begin
                        state_q <= ST_WAIT_VS;
                    end
                end
                ST_WAIT_VS: begin
                    if (!enable_i) begin
                        state_q <= ST_IDLE;
                    end else if (vs_rise) begin
                        state_q       <= ST_WRITING;
                        frame_start_o <= 1'b1;
                    end
                end
                ST_WRITING: begin
                    if (frame_done_i) begin
                        rd_bufn_o   <= wr_bufn_o;
                        wr_bufn_o   <= next_bufn(wr_bufn_o, LAST_BUFN);
                        rd_valid_o  <= 1'b1;
                        frame_cnt_o <= frame_cnt_o + 1'b1;
                        if (vs_rise) begin
                            frame_start_o <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT_VS;
                        end
                    end else if (vs_rise) begin
                        // Overrun: restart into the same buffer.
                        drop_o        <= 1'b1;
                        frame_start_o <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state_q == ST_WRITING);

    a_wr_range: assert property (@(posedge clk) disable iff (!rst_n)
        wr_bufn_o <= LAST_BUFN);

    a_rd_range: assert property (@(posedge clk) disable iff (!rst_n)
        rd_bufn_o <= LAST_BUFN);

    a_ring_order: assert property (@(posedge clk) disable iff (!rst_n)
        rd_valid_o |-> (rd_bufn_o == ((wr_bufn_o == '0) ? LAST_BUFN : wr_bufn_o - 1'b1)));

    a_wr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_WRITING && !frame_done_i) |=> $stable(wr_bufn_o));

    a_drop_with_start: assert property (@(posedge clk) disable iff (!rst_n)
        drop_o |-> frame_start_o);

endmodule

// File: tb/tb_vs_wbuf_ctrl.sv
// Scoreboard bench for vs_wbuf_ctrl: one ring of 3 with active-high vs, one ring of 2
// with active-low vs; directed frames push hand-computed expectations, monitors compare.
module tb_vs_wbuf_ctrl;

    typedef struct {
        logic        fs;
        logic        drop;
        logic [7:0]  wr;
        logic [7:0]  rd;
        logic        rv;
        logic [15:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: BUF_LENTH=3, VS_POL=1
    logic        rst_n_a = 1'b0, en_a = 1'b0, vs_a = 1'b0, done_a = 1'b0;
    logic [7:0]  wr_a, rd_a;
    logic        rv_a, fs_a, drop_a, busy_a;
    logic [15:0] cnt_a;

    // Instance B: BUF_LENTH=2, VS_POL=0
    logic        rst_n_b = 1'b0, en_b = 1'b0, vs_b = 1'b1, done_b = 1'b0;
    logic [7:0]  wr_b, rd_b;
    logic        rv_b, fs_b, drop_b, busy_b;
    logic [15:0] cnt_b;

    vs_wbuf_ctrl #(.BUF_LENTH(3), .VS_POL(1), .FRAME_CNT_W(16)) u_dut_a (
        .clk(clk), .rst_n(rst_n_a), .enable_i(en_a), .vs_i(vs_a), .frame_done_i(done_a),
        .wr_bufn_o(wr_a), .rd_bufn_o(rd_a), .rd_valid_o(rv_a), .frame_start_o(fs_a),
        .drop_o(drop_a), .busy_o(busy_a), .frame_cnt_o(cnt_a)
    );

    vs_wbuf_ctrl #(.BUF_LENTH(2), .VS_POL(0), .FRAME_CNT_W(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n_b), .enable_i(en_b), .vs_i(vs_b), .frame_done_i(done_b),
        .wr_bufn_o(wr_b), .rd_bufn_o(rd_b), .rd_valid_o(rv_b), .frame_start_o(fs_b),
        .drop_o(drop_b), .busy_o(busy_b), .frame_cnt_o(cnt_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endfunction

    function automatic exp_t mk(input logic fs, input logic dr, input int wr, input int rd,
                                input logic rv, input int cnt);
        exp_t e;
        e.fs = fs; e.drop = dr; e.wr = 8'(wr); e.rd = 8'(rd); e.rv = rv; e.cnt = 16'(cnt);
        return e;
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic vs_pulse_a();
        vs_a = 1'b1; step(2); vs_a = 1'b0; step(3);
    endtask

    task automatic done_pulse_a();
        done_a = 1'b1; step(1); done_a = 1'b0; step(3);
    endtask

    // Monitors: any frame_start, drop or counter change is an event that must match the queue head.
    logic [15:0] prev_cnt_a = '0;
    logic [15:0] prev_cnt_b = '0;

    always @(negedge clk) begin
        if (!rst_n_a) begin
            prev_cnt_a = '0;
        end else begin
            if (fs_a || drop_a || cnt_a != prev_cnt_a) begin
                if (q_a.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_unexpected_event fs=%0b drop=%0b cnt=%0d required no event at %0t",
                             fs_a, drop_a, cnt_a, $time);
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    chk("a_frame_start", 32'(fs_a), 32'(e.fs));
                    chk("a_drop", 32'(drop_a), 32'(e.drop));
                    chk("a_wr_bufn", 32'(wr_a), 32'(e.wr));
                    chk("a_rd_bufn", 32'(rd_a), 32'(e.rd));
                    chk("a_rd_valid", 32'(rv_a), 32'(e.rv));
                    chk("a_frame_cnt", 32'(cnt_a), 32'(e.cnt));
                end
            end
            prev_cnt_a = cnt_a;
        end
    end

    always @(negedge clk) begin
        if (!rst_n_b) begin
            prev_cnt_b = '0;
        end else begin
            if (fs_b || drop_b || cnt_b != prev_cnt_b) begin
                if (q_b.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_unexpected_event fs=%0b drop=%0b cnt=%0d required no event at %0t",
                             fs_b, drop_b, cnt_b, $time);
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    chk("b_frame_start", 32'(fs_b), 32'(e.fs));
                    chk("b_drop", 32'(drop_b), 32'(e.drop));
                    chk("b_wr_bufn", 32'(wr_b), 32'(e.wr));
                    chk("b_rd_bufn", 32'(rd_b), 32'(e.rd));
                    chk("b_rd_valid", 32'(rv_b), 32'(e.rv));
                    chk("b_frame_cnt", 32'(cnt_b), 32'(e.cnt));
                end
            end
            prev_cnt_b = cnt_b;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int b_fs_wr[4] = '{0, 1, 0, 1};
        int b_fs_rd[4] = '{1, 0, 1, 0};
        int b_dn_wr[4] = '{1, 0, 1, 0};
        int b_dn_rd[4] = '{0, 1, 0, 1};

        // ---------------- Instance A: reset values ----------------
        step(3);
        chk("a_rst_wr", 32'(wr_a), 32'd0);
        chk("a_rst_rd", 32'(rd_a), 32'd2);
        chk("a_rst_rv", 32'(rv_a), 32'd0);
        chk("a_rst_fs", 32'(fs_a), 32'd0);
        chk("a_rst_drop", 32'(drop_a), 32'd0);
        chk("a_rst_busy", 32'(busy_a), 32'd0);
        chk("a_rst_cnt", 32'(cnt_a), 32'd0);
        rst_n_a = 1'b1;
        step(1);
        en_a = 1'b1;
        step(3);

        // Frame 1 into buffer 0, with start latency check
        q_a.push_back(mk(1, 0, 0, 2, 0, 0));
        chk("a_fs_before_edge", 32'(fs_a), 32'd0);
        vs_a = 1'b1;
        step(1);
        chk("a_fs_latency", 32'(fs_a), 32'd1);
        chk("a_busy_latency", 32'(busy_a), 32'd1);
        step(1);
        chk("a_fs_one_cycle", 32'(fs_a), 32'd0);
        chk("a_busy_held", 32'(busy_a), 32'd1);
        vs_a = 1'b0;
        step(3);
        q_a.push_back(mk(0, 0, 1, 0, 1, 1));
        done_pulse_a();
        chk("a_busy_after_done", 32'(busy_a), 32'd0);

        // Frame 2 into buffer 1
        q_a.push_back(mk(1, 0, 1, 0, 1, 1));
        vs_pulse_a();
        q_a.push_back(mk(0, 0, 2, 1, 1, 2));
        done_pulse_a();

        // Frame 3 into buffer 2, finished by a coincident done + vs edge
        q_a.push_back(mk(1, 0, 2, 1, 1, 2));
        vs_pulse_a();
        q_a.push_back(mk(1, 0, 0, 2, 1, 3));
        done_a = 1'b1; vs_a = 1'b1;
        step(1);
        done_a = 1'b0;
        chk("a_coinc_busy", 32'(busy_a), 32'd1);
        chk("a_coinc_wr", 32'(wr_a), 32'd0);
        step(1);
        vs_a = 1'b0;
        step(3);
        q_a.push_back(mk(0, 0, 1, 0, 1, 4));
        done_pulse_a();

        // Async reset mid-frame
        q_a.push_back(mk(1, 0, 1, 0, 1, 4));
        vs_pulse_a();
        chk("a_busy_midframe", 32'(busy_a), 32'd1);
        rst_n_a = 1'b0;
        #1;
        chk("a_async_wr", 32'(wr_a), 32'd0);
        chk("a_async_rd", 32'(rd_a), 32'd2);
        chk("a_async_rv", 32'(rv_a), 32'd0);
        chk("a_async_cnt", 32'(cnt_a), 32'd0);
        chk("a_async_busy", 32'(busy_a), 32'd0);
        step(2);
        rst_n_a = 1'b1;
        step(2);

        // Overrun: two starts without a done
        q_a.push_back(mk(1, 0, 0, 2, 0, 0));
        vs_pulse_a();
        q_a.push_back(mk(1, 1, 0, 2, 0, 0));
        vs_pulse_a();
        chk("a_overrun_wr", 32'(wr_a), 32'd0);
        chk("a_overrun_rv", 32'(rv_a), 32'd0);
        q_a.push_back(mk(0, 0, 1, 0, 1, 1));
        done_pulse_a();

        // Enable dropped mid-frame: frame still completes, then idle
        q_a.push_back(mk(1, 0, 1, 0, 1, 1));
        vs_pulse_a();
        en_a = 1'b0;
        step(3);
        chk("a_en_low_busy", 32'(busy_a), 32'd1);
        q_a.push_back(mk(0, 0, 2, 1, 1, 2));
        done_pulse_a();
        chk("a_idle_busy", 32'(busy_a), 32'd0);
        vs_pulse_a();
        step(2);
        chk("a_idle_no_start_busy", 32'(busy_a), 32'd0);
        chk("a_idle_wr", 32'(wr_a), 32'd2);

        // ---------------- Instance B: ring of 2, active-low vs ----------------
        step(1);
        chk("b_rst_wr", 32'(wr_b), 32'd0);
        chk("b_rst_rd", 32'(rd_b), 32'd1);
        chk("b_rst_busy", 32'(busy_b), 32'd0);
        rst_n_b = 1'b1;
        step(1);
        en_b = 1'b1;
        step(3);
        chk("b_no_spurious_start", 32'(busy_b), 32'd0);
        for (int k = 0; k < 4; k++) begin
            q_b.push_back(mk(1, 0, b_fs_wr[k], b_fs_rd[k], (k > 0), k));
            vs_b = 1'b0; step(2); vs_b = 1'b1; step(3);
            q_b.push_back(mk(0, 0, b_dn_wr[k], b_dn_rd[k], 1, k + 1));
            done_b = 1'b1; step(1); done_b = 1'b0; step(3);
        end
        chk("b_final_wr", 32'(wr_b), 32'd0);
        chk("b_final_rd", 32'(rd_b), 32'd1);

        step(5);
        chk("a_queue_drained", 32'(q_a.size()), 32'd0);
        chk("b_queue_drained", 32'(q_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
